// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed seven-segment scan controller.
// Cycles through DIGITS anode selects. Each digit slot opens with a two-count
// dark guard interval before the anode is driven. The shared decoder receives
// a hex nibble and an OFF command, which implements leading-zero blanking and
// per-digit blink. New display values are double-buffered: a LOAD is held in a
// pending register and is only applied at a frame boundary, so a frame is never
// shown half old and half new.
module seg_scan_ctrl #(
  parameter int DIGITS    = 4,
  parameter int PRESCALE  = 50000,
  parameter int BLINK_DIV = 64
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  EN,
  input  logic [4*DIGITS-1:0]   VALUE,
  input  logic                  LOAD,
  output logic                  READY,
  input  logic                  BLANK_LZ,
  input  logic [DIGITS-1:0]     BLINK,
  output logic [DIGITS-1:0]     DIG_SEL,
  output logic [3:0]            NIBBLE,
  output logic                  OFF
);

  localparam int SW = $clog2(PRESCALE);
  localparam int IW = $clog2(DIGITS);
  localparam int FW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  typedef enum logic [1:0] {IDLE, GUARD, DRIVE} state_t;

  state_t                state_q, state_d;
  logic [SW-1:0]         slot_q, slot_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [FW-1:0]         frame_q, frame_d;
  logic                  phase_q, phase_d;
  logic [4*DIGITS-1:0]   pending_q, display_q, display_d;
  logic                  pend_valid_q;
  logic                  frame_start, slot_start, transfer, load_ok, off_d;

  // True when digit idx is a leading zero: it and every more significant
  // nibble are zero. Digit 0 always stays lit so a zero value still shows "0".
  function automatic logic lead_zero(input logic [4*DIGITS-1:0] v,
                                     input logic [IW-1:0]       idx);
    logic all_zero;
    all_zero = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (i >= int'(idx) && v[4*i +: 4] != 4'h0) all_zero = 1'b0;
    end
    return all_zero && (idx != '0);
  endfunction

  // Next-state logic for the scan FSM, slot/digit/frame counters and blink phase.
  always_comb begin
    // NOTE: every signal assigned here gets a default first so no latch is inferred.
    state_d     = state_q;
    slot_d      = slot_q;
    idx_d       = idx_q;
    frame_d     = frame_q;
    phase_d     = phase_q;
    frame_start = 1'b0;
    slot_start  = 1'b0;
    if (!EN) begin
      state_d = IDLE;
      slot_d  = '0;
      idx_d   = '0;
      frame_d = '0;
      phase_d = 1'b0;
    end else if (state_q == IDLE) begin
      state_d     = GUARD;
      slot_d      = '0;
      idx_d       = '0;
      frame_d     = '0;
      phase_d     = 1'b0;
      frame_start = 1'b1;
      slot_start  = 1'b1;
    end else if (slot_q == SW'(PRESCALE - 1)) begin
      state_d    = GUARD;
      slot_d     = '0;
      slot_start = 1'b1;
      if (idx_q == IW'(DIGITS - 1)) begin
        idx_d       = '0;
        frame_start = 1'b1;
        if (frame_q == FW'(BLINK_DIV - 1)) begin
          frame_d = '0;
          phase_d = ~phase_q;
        end else begin
          frame_d = frame_q + 1'b1;
        end
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end else begin
      slot_d = slot_q + 1'b1;
      // Guard covers slot counts 0 and 1; the anode turns on at count 2.
      if (slot_q == SW'(1)) state_d = DRIVE;
    end
  end

  // Double-buffer control: what the display register holds after this edge,
  // and the decoder blank command for the digit whose slot is starting.
  always_comb begin
    load_ok   = LOAD && READY;
    transfer  = pend_valid_q && (!EN || frame_start);
    display_d = transfer ? pending_q : display_q;
    off_d     = (BLANK_LZ && lead_zero(display_d, idx_d)) || (phase_d && BLINK[idx_d]);
  end

  // Load handshake: capture into pending, apply at frame start (or at once
  // while dark), and reopen READY one cycle after the transfer.
  always_ff @(posedge CLK or posedge RST) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    if (RST) begin
      pending_q    <= '0;
      pend_valid_q <= 1'b0;
      display_q    <= '0;
      READY        <= 1'b1;
    end else begin
      if (transfer) begin
        display_q    <= pending_q;
        pend_valid_q <= 1'b0;
      end
      if (load_ok) begin
        pending_q    <= VALUE;
        pend_valid_q <= 1'b1;
      end
      READY <= load_ok ? 1'b0 : ~pend_valid_q;
    end
  end

  // Scan FSM with registered anode, nibble and blank outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      slot_q  <= '0;
      idx_q   <= '0;
      frame_q <= '0;
      phase_q <= 1'b0;
      DIG_SEL <= '1;
      NIBBLE  <= 4'h0;
      OFF     <= 1'b1;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      idx_q   <= idx_d;
      frame_q <= frame_d;
      phase_q <= phase_d;
      DIG_SEL <= (state_d == DRIVE) ? ~(DIGITS'(1) << idx_d) : '1;
      if (!EN) begin
        OFF <= 1'b1;
      end else if (slot_start) begin
        // Decoder inputs settle during the guard interval, before the anode is driven.
        NIBBLE <= display_d[4*int'(idx_d) +: 4];
        OFF    <= off_d;
      end
    end
  end

endmodule
